// File: rtl/updown_key_ctrl.sv
// Up/down key front end: 2-flop sync, per-key debounce, press arbitration with lockout.
// Optional auto-repeat when UPDOWN_KEY_AUTO_REPEAT_EN is defined.
`timescale 1ns/1ps
module updown_key_ctrl #(
  parameter int DEBOUNCE      = 15,
  parameter int DB_W          = 8,
  parameter int REPEAT_DELAY  = 200,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  output logic       M,
  output logic       step,
  output logic [1:0] key_state,
  output logic [1:0] state_dbg
);

  // Handshake: none; step is a one-cycle strobe, M is valid whenever step is high.

  if (DEBOUNCE < 1 || DEBOUNCE > 255 || DEBOUNCE >= (1 << DB_W) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("updown_key_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UP_HELD   = 2'd1,
    DOWN_HELD = 2'd2
  } state_t;

  // Bit 0 = up key, bit 1 = down key throughout.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      stable_q, stable_d;
  logic [1:0]      prev_q, prev_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      press;

  state_t state_q;
  logic   m_q;
  logic   step_q;

  always_comb begin
    sync1_d  = {key_down, key_up};
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign press = stable_q & ~prev_q;

`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
  localparam int REP_W = 16;
  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  logic             rep_fire;

  // First repeat waits REPEAT_DELAY after the initial step, later ones REPEAT_PERIOD.
  assign rep_fire = rep_first_q ? (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))
                                : (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      m_q         <= 1'b0;
      step_q      <= 1'b0;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      step_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
          rep_cnt_q   <= '0;
          rep_first_q <= 1'b1;
`endif
          if (press[0] && !press[1]) begin
            state_q <= UP_HELD;
            m_q     <= 1'b0;
            step_q  <= 1'b1;
          end else if (press[1] && !press[0]) begin
            state_q <= DOWN_HELD;
            m_q     <= 1'b1;
            step_q  <= 1'b1;
          end
        end
        UP_HELD: begin
          if (!stable_q[0]) begin
            state_q <= IDLE;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
          end else if (rep_fire) begin
            step_q      <= 1'b1;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
`endif
          end
        end
        DOWN_HELD: begin
          if (!stable_q[1]) begin
            state_q <= IDLE;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
          end else if (rep_fire) begin
            step_q      <= 1'b1;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M         = m_q;
  assign step      = step_q;
  assign key_state = stable_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_updown_key_ctrl.sv
// Directed bench for updown_key_ctrl with DEBOUNCE = 4; auto-repeat part runs
// only when UPDOWN_KEY_AUTO_REPEAT_EN is defined (REPEAT_DELAY = 10, REPEAT_PERIOD = 5).
`timescale 1ns/1ps
module tb_updown_key_ctrl;

  logic       clk;
  logic       reset;
  logic       key_up;
  logic       key_down;
  logic       M;
  logic       step;
  logic [1:0] key_state;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  updown_key_ctrl #(
    .DEBOUNCE     (4),
    .DB_W         (8),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_up   (key_up),
    .key_down (key_down),
    .M        (M),
    .step     (step),
    .key_state(key_state),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       up;
    logic       dn;
    logic       exp_m;
    logic       exp_step;
    logic [1:0] exp_ks;
  } vec_t;

  vec_t vecs [16];

  // scoreboard: expected step times (segment-relative cycle index) and observed ones
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  logic        obs_m_q [$];
  int          t;
  logic        prev_step;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // driver: present keys, let one rising edge sample them, look at outputs 1ns later
  task automatic tick(input logic up, input logic dn);
    key_up   = up;
    key_down = dn;
    @(posedge clk);
    #1;
    if (step) begin
      check("no_double_step", {31'd0, prev_step}, 32'd0);
      obs_q.push_back(16'(t));
      obs_m_q.push_back(M);
    end
    prev_step = step;
    t++;
  endtask

  task automatic ticks(input int n, input logic up, input logic dn);
    for (int i = 0; i < n; i++) tick(up, dn);
  endtask

  task automatic begin_seg();
    t = 0;
    exp_q.delete();
    obs_q.delete();
    obs_m_q.delete();
  endtask

  task automatic end_seg(input string name, input logic exp_m);
    check({name, "_step_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({name, "_step_time"}, {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
      check({name, "_step_m"}, {31'd0, obs_m_q[i]}, {31'd0, exp_m});
    end
  endtask

  initial begin
    key_up    = 1'b0;
    key_down  = 1'b0;
    reset     = 1'b0;
    prev_step = 1'b0;
    t         = 0;

    // clean up press: held for vectors 0..8, released from 9; DEBOUNCE = 4
    for (int i = 0; i < 16; i++) begin
      vecs[i].up       = (i < 9);
      vecs[i].dn       = 1'b0;
      vecs[i].exp_m    = 1'b0;
      vecs[i].exp_step = (i == 6);
      vecs[i].exp_ks   = (i >= 5 && i < 14) ? 2'b01 : 2'b00;
    end

    // reset held with random key activity
    for (int i = 0; i < 10; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rst_M", {31'd0, M}, 32'd0);
      check("rst_step", {31'd0, step}, 32'd0);
      check("rst_key_state", {30'd0, key_state}, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      check("post_rst_M", {31'd0, M}, 32'd0);
      check("post_rst_step", {31'd0, step}, 32'd0);
      check("post_rst_key_state", {30'd0, key_state}, 32'd0);
    end

    // table-driven clean press
    for (int i = 0; i < 16; i++) begin
      key_up   = vecs[i].up;
      key_down = vecs[i].dn;
      @(posedge clk);
      #1;
      check($sformatf("clean_v%0d_step", i), {31'd0, step}, {31'd0, vecs[i].exp_step});
      check($sformatf("clean_v%0d_key_state", i), {30'd0, key_state}, {30'd0, vecs[i].exp_ks});
      if (vecs[i].exp_step) check("clean_M", {31'd0, M}, {31'd0, vecs[i].exp_m});
    end
    prev_step = 1'b0;
    ticks(4, 1'b0, 1'b0);

    // bounce rejection: 3 high, 2 low, then hold from index 5 -> step at 11
    begin_seg();
    ticks(3, 1'b0, 1'b1);
    ticks(2, 1'b0, 1'b0);
    ticks(12, 1'b0, 1'b1);
    ticks(10, 1'b0, 1'b0);
    exp_q.push_back(16'd11);
    end_seg("bounce", 1'b1);

    // simultaneous press: no step, M keeps 1
    begin_seg();
    ticks(10, 1'b1, 1'b1);
    check("simul_key_state", {30'd0, key_state}, 32'd3);
    check("simul_state", {30'd0, state_dbg}, 32'd0);
    ticks(8, 1'b0, 1'b0);
    check("simul_M", {31'd0, M}, 32'd1);
    end_seg("simul", 1'b0);

    // lockout: up held, down added, up released with down still held
    begin_seg();
    ticks(10, 1'b1, 1'b0);
    ticks(10, 1'b1, 1'b1);
    ticks(10, 1'b0, 1'b1);
    check("lock_key_state", {30'd0, key_state}, 32'd2);
    check("lock_state", {30'd0, state_dbg}, 32'd0);
    ticks(8, 1'b0, 1'b0);
    check("lock_M", {31'd0, M}, 32'd0);
    exp_q.push_back(16'd6);
    end_seg("lockout", 1'b0);

    // reset mid-hold
    begin_seg();
    ticks(10, 1'b1, 1'b0);
    exp_q.push_back(16'd6);
    end_seg("pre_rst_hold", 1'b0);
    check("hold_state", {30'd0, state_dbg}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_key_state", {30'd0, key_state}, 32'd0);
    check("async_rst_state", {30'd0, state_dbg}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      check("midrst_M", {31'd0, M}, 32'd0);
      check("midrst_step", {31'd0, step}, 32'd0);
      check("midrst_key_state", {30'd0, key_state}, 32'd0);
    end
    reset = 1'b1;
    begin_seg();
    ticks(10, 1'b1, 1'b0);
    ticks(8, 1'b0, 1'b0);
    exp_q.push_back(16'd6);
    end_seg("post_rst_press", 1'b0);

`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
    // down held: first step at 6, repeats at +10 then every 5; raw release sampled at 33
    begin_seg();
    ticks(33, 1'b0, 1'b1);
    ticks(20, 1'b0, 1'b0);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd16);
    exp_q.push_back(16'd21);
    exp_q.push_back(16'd26);
    exp_q.push_back(16'd31);
    exp_q.push_back(16'd36);
    end_seg("auto_repeat", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
